// File: rtl/serial_word_assembler.sv
// -----------------------------------------------------------------------------
// serial_word_assembler
//
// Collects a framed, MSB-first serial bit stream into a SIZE-bit word and
// hands the finished word to a parallel load register.
//
// A frame opens with `start`. From the next cycle on, every cycle with
// `bit_valid` high shifts one `serial_in` bit into the word. Gaps of any
// length are allowed. When the SIZE-th bit is shifted in, the word appears on
// `data_out` and `load` pulses for one cycle.
//
// Ports:
//   clk        in   rising-edge clock, the only clock
//   reset      in   synchronous, active-high; overrides every other input
//   start      in   opens a frame; during a frame it restarts the frame
//   serial_in  in   serial data bit, MSB first
//   bit_valid  in   qualifies serial_in; ignored while idle
//   abort      in   drops a partial word and returns to idle
//   data_out   out  last completed word; unchanged by aborts and restarts
//   load       out  one-cycle strobe while data_out holds a new word
//   busy       out  high while a frame is being collected
//   frame_err  out  one-cycle pulse when start arrives mid-frame
//
// All outputs are registered.
// -----------------------------------------------------------------------------
module serial_word_assembler #(
    parameter int SIZE = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            serial_in,
    input  logic            bit_valid,
    input  logic            abort,
    output logic [SIZE-1:0] data_out,
    output logic            load,
    output logic            busy,
    output logic            frame_err
);

    localparam int CNT_W = (SIZE > 1) ? $clog2(SIZE) : 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(SIZE - 1);

    typedef enum logic {
        IDLE    = 1'b0,
        COLLECT = 1'b1
    } state_t;

    state_t            state_q;
    logic [SIZE-1:0]   shift_q;
    logic [CNT_W-1:0]  count_q;
    logic [SIZE-1:0]   data_q;
    logic              load_q;
    logic              busy_q;
    logic              frame_err_q;

    // Word with the current bit appended. On the last bit this value goes
    // straight to data_out, so load never sees a half-updated word.
    logic [SIZE-1:0]   shift_d;
    assign shift_d = {shift_q[SIZE-2:0], serial_in};

    // NOTE: state registers use non-blocking assignments only. Every register
    // then samples its pre-edge value, whatever the order of the statements.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            shift_q     <= '0;
            count_q     <= '0;
            data_q      <= '0;
            load_q      <= 1'b0;
            busy_q      <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            // NOTE: both pulses default low here. Only the branch that raises
            // a pulse assigns it, so each pulse lasts exactly one cycle.
            load_q      <= 1'b0;
            frame_err_q <= 1'b0;

            case (state_q)
                IDLE: begin
                    // A bit that arrives together with start is not captured.
                    if (start) begin
                        state_q <= COLLECT;
                        busy_q  <= 1'b1;
                        shift_q <= '0;
                        count_q <= '0;
                    end
                end

                COLLECT: begin
                    // Priority: abort, then start, then bit_valid.
                    if (abort) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        shift_q <= '0;
                        count_q <= '0;
                    end else if (start) begin
                        shift_q     <= '0;
                        count_q     <= '0;
                        frame_err_q <= 1'b1;
                    end else if (bit_valid) begin
                        if (count_q == LAST_IDX) begin
                            data_q  <= shift_d;
                            load_q  <= 1'b1;
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                            count_q <= '0;
                        end else begin
                            shift_q <= shift_d;
                            count_q <= count_q + CNT_W'(1);
                        end
                    end
                end

                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign data_out  = data_q;
    assign load      = load_q;
    assign busy      = busy_q;
    assign frame_err = frame_err_q;

endmodule
